// File: rtl/imm_bus_sequencer_pkg.sv
// rtl/imm_bus_sequencer_pkg.sv - shared states, opcodes and field codes for the bus sequencer
package imm_bus_sequencer_pkg;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_F0, ST_F1, ST_F2, ST_F3, ST_D,
    ST_I0, ST_I1, ST_I2,
    ST_L0, ST_L1, ST_L2, ST_L3,
    ST_S0, ST_S1, ST_S2, ST_S3,
    ST_B0, ST_B1, ST_B2, ST_B3, ST_B4, ST_B5,
    ST_J0, ST_J1, ST_J2, ST_J3,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_INC4  = 3'd2;
  localparam logic [2:0] ALU_ADDM4 = 3'd3;
  localparam logic [2:0] ALU_FUNC  = 3'd4;

  localparam logic [1:0] REG_RS1 = 2'd0;
  localparam logic [1:0] REG_RS2 = 2'd1;
  localparam logic [1:0] REG_RD  = 2'd2;

  // States that wait on the memory and are therefore guarded by the watchdog.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_F1) || (s == ST_L3) || (s == ST_S3);
  endfunction

endpackage

// File: rtl/imm_bus_sequencer_busy_watchdog.sv
// rtl/imm_bus_sequencer_busy_watchdog.sv - counts consecutive mem_busy cycles in a memory state
module busy_watchdog #(
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic busy,
  output logic expired
);

  localparam int W = $clog2(BUSY_TIMEOUT + 2);

  logic [W-1:0] count;

  // Memory states are never back to back, so clearing while inactive is a clear on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (busy && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = active && busy && (count == W'(BUSY_TIMEOUT));

endmodule

// File: rtl/imm_bus_sequencer.sv
// rtl/imm_bus_sequencer.sv - hardwired Moore control FSM for the bus-based RISC-V datapath
module imm_bus_sequencer
  import imm_bus_sequencer_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             mem_busy,
  input  logic             br_cond,
  output logic [1:0]       imm_sel,
  output logic             imm_en,
  output logic             pc_en,
  output logic             alu_en,
  output logic             reg_en,
  output logic [1:0]       reg_sel,
  output logic             reg_wr,
  output logic             pc_ld,
  output logic             ir_ld,
  output logic             a_ld,
  output logic             b_ld,
  output logic             ma_ld,
  output logic [2:0]       alu_op,
  output logic             mem_en,
  output logic             mem_wr,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instret
);

  state_t state, next;
  logic   expired;

  busy_watchdog #(.BUSY_TIMEOUT(BUSY_TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .active  (is_mem_state(state)),
    .busy    (mem_busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    case (state)
      ST_IDLE: if (run) next = ST_F0;
      ST_F0:   next = ST_F1;
      ST_F1: begin
        if (expired)        next = ST_ERR;
        else if (!mem_busy) next = ST_F2;
      end
      ST_F2:   next = ST_F3;
      ST_F3:   next = ST_D;
      ST_D: begin
        case (opcode)
          OP_ALUI:   next = ST_I0;
          OP_LOAD:   next = ST_L0;
          OP_STORE:  next = ST_S0;
          OP_BRANCH: next = ST_B0;
          OP_JAL:    next = ST_J0;
          default:   next = ST_ERR;
        endcase
      end
      ST_I0:   next = ST_I1;
      ST_I1:   next = ST_I2;
      ST_I2:   next = ST_DONE;
      ST_L0:   next = ST_L1;
      ST_L1:   next = ST_L2;
      ST_L2:   next = ST_L3;
      ST_S0:   next = ST_S1;
      ST_S1:   next = ST_S2;
      ST_S2:   next = ST_S3;
      ST_L3, ST_S3: begin
        if (expired)        next = ST_ERR;
        else if (!mem_busy) next = ST_DONE;
      end
      ST_B0:   next = ST_B1;
      ST_B1:   next = ST_B2;
      ST_B2:   next = br_cond ? ST_B3 : ST_DONE;
      ST_B3:   next = ST_B4;
      ST_B4:   next = ST_B5;
      ST_B5:   next = ST_DONE;
      ST_J0:   next = ST_J1;
      ST_J1:   next = ST_J2;
      ST_J2:   next = ST_J3;
      ST_J3:   next = ST_DONE;
      ST_DONE: next = run ? ST_F0 : ST_IDLE;
      ST_ERR:  next = ST_ERR;
      default: next = ST_IDLE;
    endcase
  end

  always_comb begin
    imm_sel = IMM_I;
    imm_en  = 1'b0;
    pc_en   = 1'b0;
    alu_en  = 1'b0;
    reg_en  = 1'b0;
    reg_sel = REG_RS1;
    reg_wr  = 1'b0;
    pc_ld   = 1'b0;
    ir_ld   = 1'b0;
    a_ld    = 1'b0;
    b_ld    = 1'b0;
    ma_ld   = 1'b0;
    alu_op  = ALU_ADD;
    mem_en  = 1'b0;
    mem_wr  = 1'b0;
    case (state)
      ST_F0: begin pc_en = 1'b1; ma_ld = 1'b1; end
      ST_F1: begin mem_en = 1'b1; ir_ld = 1'b1; end
      ST_F2, ST_B3, ST_J1: begin pc_en = 1'b1; a_ld = 1'b1; end
      ST_F3: begin alu_en = 1'b1; alu_op = ALU_INC4; pc_ld = 1'b1; end
      ST_I0, ST_L0, ST_S0, ST_B0: begin reg_en = 1'b1; reg_sel = REG_RS1; a_ld = 1'b1; end
      ST_I1, ST_L1: begin imm_sel = IMM_I; imm_en = 1'b1; b_ld = 1'b1; end
      ST_I2: begin alu_en = 1'b1; alu_op = ALU_FUNC; reg_sel = REG_RD; reg_wr = 1'b1; end
      ST_L2, ST_S2: begin alu_en = 1'b1; alu_op = ALU_ADD; ma_ld = 1'b1; end
      ST_L3: begin mem_en = 1'b1; reg_sel = REG_RD; reg_wr = 1'b1; end
      ST_S1: begin imm_sel = IMM_S; imm_en = 1'b1; b_ld = 1'b1; end
      // Store data comes from rs2 while the memory is written, so the memory does not drive.
      ST_S3: begin reg_en = 1'b1; reg_sel = REG_RS2; mem_en = 1'b1; mem_wr = 1'b1; end
      ST_B1: begin reg_en = 1'b1; reg_sel = REG_RS2; b_ld = 1'b1; end
      ST_B2: alu_op = ALU_SUB;
      ST_B4: begin imm_sel = IMM_B; imm_en = 1'b1; b_ld = 1'b1; end
      ST_B5, ST_J3: begin alu_en = 1'b1; alu_op = ALU_ADDM4; pc_ld = 1'b1; end
      ST_J0: begin pc_en = 1'b1; reg_sel = REG_RD; reg_wr = 1'b1; end
      ST_J2: begin imm_sel = IMM_J; imm_en = 1'b1; b_ld = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      if (state == ST_DONE)                  instret <= instret + 1'b1;
      if (state == ST_D && next == ST_ERR)   illegal <= 1'b1;
      if (expired)                           timeout <= 1'b1;
    end
  end

  a_one_bus_driver: assert property (@(posedge clk) disable iff (rst)
    $onehot0({imm_en, pc_en, alu_en, reg_en, mem_en & ~mem_wr}));

endmodule

// File: tb/tb_imm_bus_sequencer.sv
// tb/tb_imm_bus_sequencer.sv - randomized self-checking bench for imm_bus_sequencer
module tb_imm_bus_sequencer;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        mem_busy = 1'b0;
  logic        br_cond = 1'b0;
  logic [1:0]  imm_sel, reg_sel;
  logic [2:0]  alu_op;
  logic        imm_en, pc_en, alu_en, reg_en, reg_wr, pc_ld, ir_ld, a_ld, b_ld, ma_ld;
  logic        mem_en, mem_wr, illegal, timeout;
  logic [31:0] instret;

  imm_bus_sequencer #(.BUSY_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem_busy(mem_busy), .br_cond(br_cond),
    .imm_sel(imm_sel), .imm_en(imm_en), .pc_en(pc_en), .alu_en(alu_en), .reg_en(reg_en),
    .reg_sel(reg_sel), .reg_wr(reg_wr), .pc_ld(pc_ld), .ir_ld(ir_ld), .a_ld(a_ld), .b_ld(b_ld),
    .ma_ld(ma_ld), .alu_op(alu_op), .mem_en(mem_en), .mem_wr(mem_wr), .illegal(illegal),
    .timeout(timeout), .instret(instret)
  );

  always #5 clk = ~clk;

  logic [18:0] obs;
  assign obs = {imm_sel, imm_en, pc_en, alu_en, reg_en, reg_sel, reg_wr, pc_ld, ir_ld,
                a_ld, b_ld, ma_ld, alu_op, mem_en, mem_wr};

  localparam logic [18:0] V_IMM_EN = 19'h10000;
  localparam logic [18:0] V_PC_EN  = 19'h08000;
  localparam logic [18:0] V_ALU_EN = 19'h04000;
  localparam logic [18:0] V_REG_EN = 19'h02000;
  localparam logic [18:0] V_REG_WR = 19'h00400;
  localparam logic [18:0] V_PC_LD  = 19'h00200;
  localparam logic [18:0] V_IR_LD  = 19'h00100;
  localparam logic [18:0] V_A_LD   = 19'h00080;
  localparam logic [18:0] V_B_LD   = 19'h00040;
  localparam logic [18:0] V_MA_LD  = 19'h00020;
  localparam logic [18:0] V_MEM_EN = 19'h00002;
  localparam logic [18:0] V_MEM_WR = 19'h00001;

  function automatic logic [18:0] isel(input int x); return 19'(x) << 17; endfunction
  function automatic logic [18:0] rsel(input int x); return 19'(x) << 11; endfunction
  function automatic logic [18:0] aop(input int x);  return 19'(x) << 2;  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  int drv_cnt;
  always @(negedge clk) begin
    if (!rst) begin
      drv_cnt = int'(imm_en) + int'(pc_en) + int'(alu_en) + int'(reg_en) + int'(mem_en & ~mem_wr);
      check("bus_onehot", 32'(drv_cnt <= 1), 32'd1);
    end
  end

  // Reference: the expected strobe vector and inputs for every cycle of one instruction.
  typedef struct packed {
    logic [18:0] v;
    logic        busy;
    logic        br;
  } step_t;

  step_t q[$];
  logic  exp_ill = 1'b0;
  logic  exp_to  = 1'b0;
  int    exp_ret = 0;

  task automatic pb(input logic [18:0] v, input logic busy, input logic br);
    step_t s;
    s.v = v; s.busy = busy; s.br = br;
    q.push_back(s);
  endtask

  task automatic p(input logic [18:0] v);
    pb(v, 1'b0, 1'($urandom));
  endtask

  task automatic mem_stage(input logic [18:0] v, input int n, output logic to);
    int k;
    k  = (n > TO) ? TO + 1 : n;
    to = (n > TO);
    for (int i = 0; i < k; i++) pb(v, 1'b1, 1'($urandom));
    if (to) begin
      p('0);
      exp_to = 1'b1;
    end else begin
      p(v);
    end
  endtask

  task automatic plan(input logic [6:0] op, input logic br, input int fb, input int mb,
                      output logic done);
    logic to;
    q.delete();
    done = 1'b0;
    p(V_PC_EN | V_MA_LD);
    mem_stage(V_MEM_EN | V_IR_LD, fb, to);
    if (to) return;
    p(V_PC_EN | V_A_LD);
    p(V_ALU_EN | aop(2) | V_PC_LD);
    p('0);
    case (op)
      7'b0010011: begin
        p(V_REG_EN | rsel(0) | V_A_LD);
        p(isel(0) | V_IMM_EN | V_B_LD);
        p(V_ALU_EN | aop(4) | V_REG_WR | rsel(2));
      end
      7'b0000011: begin
        p(V_REG_EN | rsel(0) | V_A_LD);
        p(isel(0) | V_IMM_EN | V_B_LD);
        p(V_ALU_EN | aop(0) | V_MA_LD);
        mem_stage(V_MEM_EN | V_REG_WR | rsel(2), mb, to);
        if (to) return;
      end
      7'b0100011: begin
        p(V_REG_EN | rsel(0) | V_A_LD);
        p(isel(1) | V_IMM_EN | V_B_LD);
        p(V_ALU_EN | aop(0) | V_MA_LD);
        mem_stage(V_REG_EN | rsel(1) | V_MEM_EN | V_MEM_WR, mb, to);
        if (to) return;
      end
      7'b1100011: begin
        p(V_REG_EN | rsel(0) | V_A_LD);
        p(V_REG_EN | rsel(1) | V_B_LD);
        pb(aop(1), 1'b0, br);
        if (br) begin
          p(V_PC_EN | V_A_LD);
          p(isel(2) | V_IMM_EN | V_B_LD);
          p(V_ALU_EN | aop(3) | V_PC_LD);
        end
      end
      7'b1101111: begin
        p(V_PC_EN | rsel(2) | V_REG_WR);
        p(V_PC_EN | V_A_LD);
        p(isel(3) | V_IMM_EN | V_B_LD);
        p(V_ALU_EN | aop(3) | V_PC_LD);
      end
      default: begin
        p('0);
        exp_ill = 1'b1;
        return;
      end
    endcase
    p('0);
    done = 1'b1;
  endtask

  // Entered and left at a negedge with the sequencer idle (or in ERR afterwards).
  task automatic play(input logic [6:0] op, input logic done, input int stop_at);
    opcode = op;
    run    = 1'b1;
    foreach (q[i]) begin
      @(negedge clk);
      check("step", 32'(obs), 32'(q[i].v));
      if (i == stop_at) begin
        #1 rst = 1'b1;
        #1;
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_strobes", 32'(obs), 32'd0);
        check("rst_instret", instret, 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0; mem_busy = 1'b0;
        exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
        return;
      end
      mem_busy = q[i].busy;
      br_cond  = q[i].br;
      run      = (done && i == q.size() - 1) ? 1'b0 : 1'($urandom);
    end
    if (done) exp_ret++;
    @(negedge clk);
    mem_busy = 1'b0;
    check("rest_strobes", 32'(obs), 32'd0);
    check("instret", instret, 32'(exp_ret));
    check("illegal", 32'(illegal), 32'(exp_ill));
    check("timeout", 32'(timeout), 32'(exp_to));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_strobes", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0; mem_busy = 1'b0;
    exp_ret = 0; exp_ill = 1'b0; exp_to = 1'b0;
    check("reset_flags", 32'({illegal, timeout}), 32'd0);
    check("reset_instret", instret, 32'd0);
  endtask

  logic [6:0] ops [5] = '{7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};

  initial begin
    logic d;
    @(negedge clk);
    check("por_strobes", 32'(obs), 32'd0);
    check("por_instret", instret, 32'd0);
    check("por_flags", 32'({illegal, timeout}), 32'd0);
    rst = 1'b0;

    for (int c = 0; c < 5; c++) begin
      for (int b = 0; b < 2; b++) begin
        plan(ops[c], 1'(b), 0, 0, d);
        play(ops[c], d, -1);
      end
    end

    for (int n = 0; n < 30; n++) begin
      int c;
      c = $urandom_range(0, 4);
      plan(ops[c], 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), d);
      play(ops[c], d, -1);
    end

    plan(7'b0010011, 1'b0, TO, 0, d);
    play(7'b0010011, d, -1);

    plan(7'b0000000, 1'b0, 0, 0, d);
    play(7'b0000000, d, -1);
    for (int k = 0; k < 6; k++) begin
      run = 1'($urandom);
      @(negedge clk);
      check("err_hold", 32'(obs), 32'd0);
      check("err_illegal", 32'(illegal), 32'd1);
    end
    do_reset();

    plan(7'b0010011, 1'b0, 0, 0, d);
    play(7'b0010011, d, -1);
    plan(7'b0100011, 1'b0, 0, 10, d);
    play(7'b0100011, d, 10);

    plan(7'b0010011, 1'b0, TO + 1, 0, d);
    play(7'b0010011, d, -1);
    for (int k = 0; k < 3; k++) begin
      run = 1'($urandom);
      @(negedge clk);
      check("to_hold", 32'(obs), 32'd0);
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
